// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate in front of an on-chip synchronous SRAM.
// One outstanding transfer, programmable data-phase wait states, byte-strobed
// writes with read-after-write forwarding, and a two-cycle ERROR response.
module ahb_sram_sub #(
    parameter int PA_BITS     = 34,
    parameter int AHBW        = 64,
    parameter int DEPTH_BITS  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [PA_BITS-1:0]  HADDR,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [2:0]          HBURST,
    input  logic [1:0]          HTRANS,
    input  logic                HREADY,
    input  logic [AHBW-1:0]     HWDATA,
    input  logic [AHBW/8-1:0]   HWSTRB,
    output logic [AHBW-1:0]     HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP
);
    localparam int         STRB     = AHBW / 8;
    localparam int         LOG2B    = $clog2(STRB);
    localparam int         IDX_LO   = LOG2B;
    localparam int         IDX_HI   = LOG2B + DEPTH_BITS - 1;
    localparam int         DEPTH    = 1 << DEPTH_BITS;
    localparam logic [2:0] MAX_SIZE = 3'(LOG2B);
    localparam logic [2:0] WS       = 3'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t                  state_q;
    logic [2:0]              cnt_q;
    logic [DEPTH_BITS-1:0]   idx_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic                    hreadyout_q;
    logic                    hresp_q;
    logic [AHBW-1:0]         hrdata_q;
    logic [AHBW-1:0]         rbuf_q;
    logic [AHBW-1:0]         mem [DEPTH];

    logic                    accept;
    logic                    misaligned;
    logic                    illegal;
    logic                    commit;
    logic                    rd_issue;
    logic [DEPTH_BITS-1:0]   acc_idx;
    logic [AHBW-1:0]         rd_merged;
    logic                    unused_bits;

    // Burst type, latched size and aliased upper address bits carry no function here.
    assign unused_bits = ^{HBURST, size_q, HADDR[PA_BITS-1:IDX_HI+1]};

    assign acc_idx  = HADDR[IDX_HI:IDX_LO];
    // A new address phase is only taken while this block is not stalling the bus.
    assign accept   = HSEL & HREADY & HTRANS[1] & hreadyout_q;
    assign illegal  = (HSIZE > MAX_SIZE) | misaligned;
    assign commit   = (state_q == ST_DATA) && (cnt_q == 3'd0) && write_q;
    assign rd_issue = accept & ~illegal & ~HWRITE;

    // Address must be aligned to the transfer size.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        misaligned = 1'b0;
        for (int i = 0; i < LOG2B; i++) begin
            if (HADDR[i] && (3'(i) < HSIZE)) misaligned = 1'b1;
        end
    end

    // Array word for a new read, merged with a write committing on the same edge.
    always_comb begin
        rd_merged = mem[acc_idx];
        if (commit && (idx_q == acc_idx)) begin
            for (int b = 0; b < STRB; b++) begin
                if (HWSTRB[b]) rd_merged[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    // Array write on data-phase completion; read buffer captured on read accept.
    // NOTE: the array and its read buffer have no reset; reset must not disturb stored data.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < STRB; b++) begin
                if (HWSTRB[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
        if (rd_issue) rbuf_q <= rd_merged;
    end

    // Transfer FSM with registered HREADYOUT, HRESP and HRDATA.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (WAIT_STATES == 0) begin
                if (rd_issue) hrdata_q <= rd_merged;
            end else if ((state_q == ST_DATA) && (cnt_q == 3'd1) && !write_q) begin
                hrdata_q <= rbuf_q;
            end

            if ((state_q == ST_DATA) && (cnt_q != 3'd0)) begin
                cnt_q       <= cnt_q - 3'd1;
                hreadyout_q <= (cnt_q == 3'd1);
                hresp_q     <= 1'b0;
            end else if (state_q == ST_ERR1) begin
                state_q     <= ST_ERR2;
                hreadyout_q <= 1'b1;
                hresp_q     <= 1'b1;
            end else if (accept && illegal) begin
                state_q     <= ST_ERR1;
                hreadyout_q <= 1'b0;
                hresp_q     <= 1'b1;
            end else if (accept) begin
                state_q     <= ST_DATA;
                cnt_q       <= WS;
                idx_q       <= acc_idx;
                write_q     <= HWRITE;
                size_q      <= HSIZE;
                hreadyout_q <= (WS == 3'd0);
                hresp_q     <= 1'b0;
            end else begin
                state_q     <= ST_IDLE;
                hreadyout_q <= 1'b1;
                hresp_q     <= 1'b0;
            end
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_sub.sv
// Testbench for ahb_sram_sub: three instances (0, 2 and 3 wait states) share the
// address/data bus; a pipelined driver keeps a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_ahb_sram_sub;
    localparam int PA = 34;
    localparam int W  = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          hsel_drv;
    logic [PA-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [1:0]    htrans;
    logic [W-1:0]  hwdata;
    logic [7:0]    hwstrb;
    logic          stall_force;
    int            cur;        // selected instance, equal to its wait-state count
    logic [2:0]    cur_burst;

    logic          sel0, sel2, sel3, rdy0, rdy2, rdy3;
    logic          ro0, ro2, ro3, rs0, rs2, rs3;
    logic [W-1:0]  rd0, rd2, rd3;
    logic          hready_c, hresp_c;
    logic [W-1:0]  hrdata_c;

    assign sel0 = hsel_drv && (cur == 0);
    assign sel2 = hsel_drv && (cur == 2);
    assign sel3 = hsel_drv && (cur == 3);
    assign rdy0 = ~stall_force & ro0;
    assign rdy2 = ~stall_force & ro2;
    assign rdy3 = ~stall_force & ro3;

    always_comb begin
        case (cur)
            2:       begin hready_c = ro2; hresp_c = rs2; hrdata_c = rd2; end
            3:       begin hready_c = ro3; hresp_c = rs3; hrdata_c = rd3; end
            default: begin hready_c = ro0; hresp_c = rs0; hrdata_c = rd0; end
        endcase
    end

    ahb_sram_sub #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(rdy0),
        .HWDATA(hwdata), .HWSTRB(hwstrb), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));
    ahb_sram_sub #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel2), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(rdy2),
        .HWDATA(hwdata), .HWSTRB(hwstrb), .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2));
    ahb_sram_sub #(.WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(rdy3),
        .HWDATA(hwdata), .HWSTRB(hwstrb), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3));

    typedef struct {
        logic          wr;
        logic [PA-1:0] addr;
        logic [2:0]    size;
        logic [1:0]    trans;
        logic [2:0]    burst;
        logic [W-1:0]  wdata;
        logic [7:0]    strb;
    } xfer_t;

    typedef struct {
        logic         rd;
        logic         err;
        int           stalls;
        logic [W-1:0] data;
    } exp_t;

    xfer_t        seq[$];
    exp_t         sb[$];
    logic [W-1:0] model[int];
    int           seq_cycles;
    int           vectors     = 0;
    int           miscompares = 0;

    function automatic int key_of(input logic [PA-1:0] a);
        return cur * 4096 + int'(a[14:3]);
    endfunction

    // Reference behaviour of one transfer against the bench's own array model.
    function automatic exp_t expect_of(input xfer_t x);
        exp_t        e;
        int unsigned lowmask;
        lowmask  = (32'd1 << x.size) - 32'd1;
        e.rd     = x.trans[1] && !x.wr;
        e.err    = x.trans[1] && ((x.size > 3'd3) || ((int'(x.addr[2:0]) & lowmask) != 0));
        e.stalls = e.err ? 1 : (x.trans[1] ? cur : 0);
        e.data   = '0;
        if (e.rd && !e.err) e.data = model.exists(key_of(x.addr)) ? model[key_of(x.addr)] : 'x;
        return e;
    endfunction

    function automatic void model_write(input xfer_t x);
        exp_t         e;
        int           k;
        logic [W-1:0] tmp;
        e = expect_of(x);
        if (!x.trans[1] || !x.wr || e.err) return;
        k   = key_of(x.addr);
        tmp = model.exists(k) ? model[k] : 'x;
        for (int b = 0; b < 8; b++) begin
            if (x.strb[b]) tmp[8*b +: 8] = x.wdata[8*b +: 8];
        end
        model[k] = tmp;
    endfunction

    task automatic add(input logic w, input logic [PA-1:0] a, input logic [2:0] sz,
                       input logic [1:0] tr, input logic [W-1:0] d, input logic [7:0] st);
        xfer_t x;
        x.wr = w; x.addr = a; x.size = sz; x.trans = tr; x.burst = cur_burst;
        x.wdata = d; x.strb = st;
        seq.push_back(x);
    endtask

    task automatic wr(input logic [PA-1:0] a, input logic [W-1:0] d, input logic [7:0] st);
        add(1'b1, a, 3'd3, 2'b10, d, st);
    endtask

    task automatic rd(input logic [PA-1:0] a);
        add(1'b0, a, 3'd3, 2'b10, '0, '0);
    endtask

    task automatic drive_addr(input xfer_t x);
        hsel_drv = 1'b1; haddr = x.addr; hwrite = x.wr; hsize = x.size;
        htrans = x.trans; hburst = x.burst;
    endtask

    task automatic drive_idle();
        hsel_drv = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd0;
        htrans = 2'b00; hburst = 3'd0;
    endtask

    // Pipelined driver: address phase of beat i overlaps data phase of beat i-1.
    task automatic run_seq(input string tag);
        int           n, ai, stalls, budget;
        bit           in_dp, ready;
        exp_t         ex;
        logic [W-1:0] held;
        n = seq.size(); ai = 0; stalls = 0; budget = 0; in_dp = 0; seq_cycles = 0;
        held = '0; ex.rd = 1'b0; ex.err = 1'b0; ex.stalls = 0; ex.data = '0;
        sb.delete();
        if (n > 0) begin
            sb.push_back(expect_of(seq[0]));
            drive_addr(seq[0]);
        end
        while (ai < n || in_dp) begin
            @(negedge clk);
            ready = hready_c;
            if (in_dp) begin
                seq_cycles++;
                vectors++;
                if (hresp_c !== ex.err) begin
                    miscompares++;
                    $display("FAIL %s.hresp beat %0d: got %0b want %0b", tag, ai - 1, hresp_c, ex.err);
                end
                if (!ready) begin
                    stalls++; budget++;
                    if (ex.rd && !ex.err) begin
                        if (stalls == 1) held = hrdata_c;
                        else begin
                            vectors++;
                            if (hrdata_c !== held) begin
                                miscompares++;
                                $display("FAIL %s.hold beat %0d: got %h want %h", tag, ai - 1, hrdata_c, held);
                            end
                        end
                    end
                    if (budget > 40) begin
                        vectors++; miscompares++;
                        $display("FAIL %s.timeout beat %0d: HREADYOUT low %0d cycles, want %0d", tag, ai - 1, budget, ex.stalls);
                        drive_idle(); seq.delete();
                        @(posedge clk); #1;
                        return;
                    end
                end else begin
                    vectors++;
                    if (stalls !== ex.stalls) begin
                        miscompares++;
                        $display("FAIL %s.waits beat %0d: got %0d want %0d", tag, ai - 1, stalls, ex.stalls);
                    end
                    if (ex.rd && !ex.err) begin
                        vectors++;
                        if (hrdata_c !== ex.data) begin
                            miscompares++;
                            $display("FAIL %s.rdata beat %0d: got %h want %h", tag, ai - 1, hrdata_c, ex.data);
                        end
                    end
                end
            end
            @(posedge clk); #1;
            if (ready) begin
                in_dp = 0;
                if (ai < n) begin
                    model_write(seq[ai]);
                    hwdata = seq[ai].wdata; hwstrb = seq[ai].strb;
                    ex = sb.pop_front(); in_dp = 1; stalls = 0; budget = 0;
                    ai++;
                    if (ai < n) begin
                        sb.push_back(expect_of(seq[ai]));
                        drive_addr(seq[ai]);
                    end else drive_idle();
                end
            end
        end
        seq.delete();
    endtask

    // Start one transfer on the 3-wait instance and pull reset inside its wait states.
    task automatic reset_mid(input logic w, input logic [PA-1:0] a, input logic [W-1:0] d, input string tag);
        xfer_t x;
        x.wr = w; x.addr = a; x.size = 3'd3; x.trans = 2'b10; x.burst = 3'd0;
        x.wdata = d; x.strb = 8'hFF;
        drive_addr(x);
        @(posedge clk); #1;
        drive_idle(); hwdata = d; hwstrb = 8'hFF;
        @(posedge clk); #1;
        vectors++;
        if (hready_c !== 1'b0) begin
            miscompares++; $display("FAIL %s.wait: HREADYOUT got %0b want 0", tag, hready_c);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (hready_c !== 1'b1) begin
            miscompares++; $display("FAIL %s.hreadyout: got %0b want 1", tag, hready_c);
        end
        vectors++;
        if (hresp_c !== 1'b0) begin
            miscompares++; $display("FAIL %s.hresp: got %0b want 0", tag, hresp_c);
        end
        vectors++;
        if (hrdata_c !== '0) begin
            miscompares++; $display("FAIL %s.hrdata: got %h want 0", tag, hrdata_c);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ro0 !== 1'b1 || rs0 !== 1'b0 || rd0 !== '0) begin
            miscompares++;
            $display("FAIL por.dut0: ready/resp/rdata got %0b/%0b/%h want 1/0/0", ro0, rs0, rd0);
        end
        vectors++;
        if (ro3 !== 1'b1 || rs3 !== 1'b0 || rd3 !== '0) begin
            miscompares++;
            $display("FAIL por.dut3: ready/resp/rdata got %0b/%0b/%h want 1/0/0", ro3, rs3, rd3);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cur = 3;
        wr(34'h100, 64'hA5A5_0F0F_1234_5678, 8'hFF);
        wr(34'h108, 64'h0BAD_F00D_DEAD_BEEF, 8'hFF);
        rd(34'h100);
        run_seq("reset_pre");
        reset_mid(1'b0, 34'h100, '0, "reset_mid_read");
        reset_mid(1'b1, 34'h108, 64'h7777_6666_5555_4444, "reset_mid_write");
        rd(34'h100);
        rd(34'h108);
        run_seq("reset_post");
    endtask

    task automatic test_write_read();
        cur = 0;
        wr(34'h80, 64'h1122_3344_5566_7788, 8'hFF);
        rd(34'h80);
        rd(34'h2_0000_0080);
        add(1'b0, 34'h84, 3'd2, 2'b10, '0, '0);
        run_seq("write_read");
    endtask

    task automatic test_partial_fwd();
        cur = 0;
        wr(34'h80, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        wr(34'h80, 64'h5566_7788_1122_3344, 8'h0F);
        rd(34'h80);
        wr(34'h88, 64'h0123_4567_89AB_CDEF, 8'hFF);
        wr(34'h88, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81);
        rd(34'h88);
        run_seq("partial_fwd");
    endtask

    task automatic test_misaligned();
        cur = 0;
        wr(34'h88, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        add(1'b0, 34'h82, 3'd2, 2'b10, '0, '0);
        rd(34'h88);
        add(1'b1, 34'h8A, 3'd2, 2'b10, 64'h1111_2222_3333_4444, 8'hFF);
        add(1'b0, 34'h88, 3'd4, 2'b10, '0, '0);
        add(1'b0, 34'h81, 3'd0, 2'b10, '0, '0);
        add(1'b0, 34'h86, 3'd1, 2'b10, '0, '0);
        add(1'b0, 34'h86, 3'd2, 2'b10, '0, '0);
        rd(34'h88);
        run_seq("misaligned");
    endtask

    task automatic test_burst();
        cur = 2;
        cur_burst = 3'b011;
        for (int i = 0; i < 4; i++) begin
            add(1'b1, 34'h200 + 34'(8 * i), 3'd3, (i == 0) ? 2'b10 : 2'b11,
                {$urandom, $urandom}, 8'hFF);
        end
        run_seq("burst_wr");
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 34'h200 + 34'(8 * i), 3'd3, (i == 0) ? 2'b10 : 2'b11, '0, '0);
        end
        run_seq("burst_rd");
        vectors++;
        if (seq_cycles !== 12) begin
            miscompares++; $display("FAIL burst_rd.cycles: got %0d want 12", seq_cycles);
        end
        add(1'b0, 34'h200, 3'd3, 2'b10, '0, '0);
        add(1'b0, 34'h208, 3'd3, 2'b01, '0, '0);
        add(1'b0, 34'h208, 3'd3, 2'b11, '0, '0);
        add(1'b0, 34'h210, 3'd3, 2'b11, '0, '0);
        add(1'b0, 34'h218, 3'd3, 2'b11, '0, '0);
        run_seq("burst_busy");
        vectors++;
        if (seq_cycles !== 13) begin
            miscompares++; $display("FAIL burst_busy.cycles: got %0d want 13", seq_cycles);
        end
        cur_burst = 3'b000;
    endtask

    task automatic test_stall();
        xfer_t        x;
        exp_t         ex;
        logic [W-1:0] yv, xv;
        cur = 0;
        yv  = 64'h9999_8888_7777_6666;
        xv  = 64'h0102_0304_0506_0708;
        wr(34'h90, yv, 8'hFF);
        wr(34'h98, xv, 8'hFF);
        rd(34'h98);
        run_seq("stall_pre");
        x.wr = 1'b0; x.addr = 34'h90; x.size = 3'd3; x.trans = 2'b10; x.burst = 3'd0;
        x.wdata = '0; x.strb = '0;
        sb.delete();
        sb.push_back(expect_of(x));
        stall_force = 1'b1;
        drive_addr(x);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (hrdata_c !== xv || hready_c !== 1'b1) begin
                miscompares++;
                $display("FAIL stall.hold%0d: rdata/ready got %h/%0b want %h/1", i, hrdata_c, hready_c, xv);
            end
            @(posedge clk);
        end
        #1 stall_force = 1'b0;
        @(posedge clk); #1;
        drive_idle();
        ex = sb.pop_front();
        @(negedge clk);
        vectors++;
        if (hrdata_c !== ex.data || hready_c !== 1'b1 || hresp_c !== 1'b0) begin
            miscompares++;
            $display("FAIL stall.accept: rdata/ready/resp got %h/%0b/%0b want %h/1/0",
                     hrdata_c, hready_c, hresp_c, ex.data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        cur = 0;
        for (int i = 0; i < 4; i++) wr(34'h300 + 34'(8 * i), {$urandom, $urandom}, 8'hFF);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr(34'h300 + 34'(8 * $urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom_range(1, 255)));
            else
                rd(34'h300 + 34'(8 * $urandom_range(0, 3)));
        end
        run_seq("back_to_back");
        vectors++;
        if (seq_cycles !== 16) begin
            miscompares++; $display("FAIL back_to_back.cycles: got %0d want 16", seq_cycles);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = 0; cur_burst = 3'd0; stall_force = 1'b0;
        hwdata = '0; hwstrb = '0;
        drive_idle();
        #1 rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_partial_fwd();
        test_misaligned();
        test_burst();
        test_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahb_sram_sub.md
Name: ahb_sram_sub

Overview:
- AHB-Lite subordinate (responder) that fronts an on-chip synchronous SRAM array.
- Serves transfers issued by the core's bus manager, after arbitration and external HSEL decode.
- Features: configurable wait states, byte-strobed writes, read-after-write forwarding across pipelined transfers, two-cycle ERROR response for illegal transfers.
- Used as boot RAM / scratchpad on the SoC bus.

Parameters:
- PA_BITS, 34, physical address width.
- AHBW, 64, data bus width in bits (32 or 64).
- DEPTH_BITS, 12, log2 of array depth in AHBW-bit words.
- WAIT_STATES, 0, data-phase stall cycles per accepted transfer (0..7).

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  reset.
- HSEL  input  1  subordinate select from external address decoder.
- HADDR  input  PA_BITS  address-phase address.
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  transfer size, log2 bytes.
- HBURST  input  3  burst type (informational only).
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  input  1  bus-level ready (muxed HREADYOUT of all subordinates).
- HWDATA  input  AHBW  write data, valid in the data phase.
- HWSTRB  input  AHBW/8  byte write enables, valid in the data phase.
- HRDATA  output  AHBW  read data.
- HREADYOUT  output  1  this subordinate's ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (HRESETn). On assertion, at any time and including mid-transfer:
  - FSM goes to IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0.
  - Any write not yet committed is dropped. Array contents are not cleared.
- Accept: an address phase is accepted on a rising edge where HSEL & HREADY & HTRANS[1].
  - On accept, latch: word index = HADDR[log2(AHBW/8)+DEPTH_BITS-1 : log2(AHBW/8)], HWRITE, HSIZE.
  - Upper address bits are ignored (aliasing).
  - IDLE/BUSY, or HSEL=0, is never accepted. The next cycle is OKAY with HREADYOUT=1.
- Illegal transfer: HSIZE > log2(AHBW/8), or HADDR not aligned to 2^HSIZE bytes.
- FSM states: IDLE, DATA, ERR1, ERR2.
- IDLE:
  - Legal accept -> DATA; wait counter loaded with WAIT_STATES.
  - Illegal accept -> ERR1.
- DATA:
  - HREADYOUT = (counter==0), HRESP=0. Counter decrements while nonzero.
  - When the counter reaches 0 the data phase completes. A new accept in that same cycle reloads the counter or goes to ERR1; otherwise -> IDLE.
- ERR1: HREADYOUT=0, HRESP=1; -> ERR2. The array is untouched.
- ERR2: HREADYOUT=1, HRESP=1.
  - A legal accept in this cycle -> DATA; an illegal accept -> ERR1; else -> IDLE.
  - An illegal accept from ERR2 is a consecutive error and is still two cycles.
- Reads:
  - The array read is issued on the accept edge.
  - HRDATA is registered and valid in the completing data-phase cycle.
  - HRDATA is held stable through wait states and held after completion until the next read completes.
  - The full AHBW word is returned regardless of HSIZE.
- Writes: committed to the array on the edge that completes the data phase, using HWSTRB for byte enables. HSIZE does not mask; the manager supplies correct strobes.
- Read-after-write: a read accepted on the same edge that commits a write to the same word index returns merged data. Per byte, the HWDATA byte is used where HWSTRB=1, otherwise the array byte. Zero-wait back-to-back write-then-read must return the new data.
- Bursts: HBURST is ignored; each beat is an independent transfer with its own WAIT_STATES. BUSY inside a burst gets a zero-wait OKAY.
- HREADY low with HSEL & HTRANS[1] (another subordinate stalling): not accepted; the same address phase is re-sampled on a later edge.
- Throughput with WAIT_STATES=0: one transfer per cycle, sustained.

Test Plan:
- Reset default, AHBW=64: assert HRESETn=0 mid-read with WAIT_STATES=3 -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; array contents retained.
- Write then read: NONSEQ write 0x80, HSIZE=3, HWDATA=0x1122334455667788, HWSTRB=0xFF; then NONSEQ read 0x80 back-to-back -> HRDATA=0x1122334455667788 in the next cycle, HREADYOUT=1.
- Partial write forwarding: word 0x80 holds 0xAAAA...AA; write with HWSTRB=0x0F, HWDATA=0x...11223344; back-to-back read -> 0xAAAAAAAA11223344.
- Misaligned read at HADDR=0x82, HSIZE=2 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; array unchanged; a following legal read returns OKAY.
- WAIT_STATES=2: INCR4 read burst -> each beat shows HREADYOUT low 2 cycles then high; total 12 data-phase cycles; HRDATA stable during stalls.
- HSEL=1, HTRANS=NONSEQ, HREADY=0 for 3 cycles -> no accept and no array access; accepted on the first cycle with HREADY=1.
